// File: rtl/mo_pkg.sv
// Motion-object descriptor layout and scanner FSM state encodings.
package mo_pkg;

   localparam logic [1:0] MO_PIC  = 2'd0;
   localparam logic [1:0] MO_Y    = 2'd1;
   localparam logic [1:0] MO_X    = 2'd2;
   localparam logic [1:0] MO_ATTR = 2'd3;

   localparam int MO_ATTR_VFLIP = 7;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD_Y = 3'd1;
   localparam logic [2:0] S_CHK  = 3'd2;
   localparam logic [2:0] S_RD_X = 3'd3;
   localparam logic [2:0] S_RD_A = 3'd4;
   localparam logic [2:0] S_LAT  = 3'd5;
   localparam logic [2:0] S_EMIT = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

endpackage

// File: rtl/mo_vmatch.sv
// Vertical intersection test: does an object at y cover line vline, and on which row.
// Combinational; Y wraps modulo 256 so objects near the bottom reappear at the top.
module mo_vmatch #(
   parameter int OBJ_H = 16
) (
   input  logic [7:0]               vline,
   input  logic [7:0]               y,
   output logic                     hit,
   output logic [$clog2(OBJ_H)-1:0] row
);

   localparam logic [8:0] HEIGHT = 9'(OBJ_H);

   logic [7:0] diff;

   always_comb begin
      diff = vline - y;
      hit  = {1'b0, diff} < HEIGHT;
      row  = diff[$clog2(OBJ_H)-1:0];
   end

endmodule

// File: rtl/mo_line_scanner.sv
// Walks the MO RAM once per line_start and hands intersecting objects to the drawer.
// Miss = 2 cycles, hit = 5 cycles + EMIT; EMIT holds obj_* until obj_ready, line_start aborts.
module mo_line_scanner #(
   parameter int NUM_OBJ      = 64,
   parameter int OBJ_H        = 16,
   parameter int MAX_PER_LINE = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     line_start,
   input  logic [7:0]               vline,
   output logic [7:0]               ram_a,
   output logic                     ram_r_n,
   input  logic [7:0]               ram_o,
   output logic                     obj_valid,
   input  logic                     obj_ready,
   output logic [7:0]               obj_pic,
   output logic [7:0]               obj_x,
   output logic [7:0]               obj_attr,
   output logic [$clog2(OBJ_H)-1:0] obj_row,
   output logic                     scan_busy,
   output logic                     scan_done,
   output logic                     overflow
);

   import mo_pkg::*;

   localparam int OW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam int CW = $clog2(MAX_PER_LINE + 1);
   localparam int RW = $clog2(OBJ_H);
   localparam logic [RW-1:0] ROW_MAX = RW'(OBJ_H - 1);

   logic [2:0]    state;
   logic [7:0]    vline_q;
   logic [OW-1:0] obj_q;
   logic [CW-1:0] cnt_q;
   logic [RW-1:0] row_q;
   logic [7:0]    pic_q;
   logic [7:0]    x_q;
   logic [7:0]    attr_q;
   logic          ovf_q;

   logic          hit;
   logic [RW-1:0] hit_row;
   logic          last_obj;

   mo_vmatch #(.OBJ_H(OBJ_H)) u_vmatch (
      .vline (vline_q),
      .y     (ram_o),
      .hit   (hit),
      .row   (hit_row)
   );

   assign last_obj = (obj_q == OW'(NUM_OBJ - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         vline_q <= '0;
         obj_q   <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         pic_q   <= '0;
         x_q     <= '0;
         attr_q  <= '0;
         ovf_q   <= 1'b0;
      end else if (line_start) begin
         // Restart from any state, including an abort mid-scan or in DONE.
         vline_q <= vline;
         obj_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         state   <= S_RD_Y;
      end else begin
         case (state)
            S_RD_Y: state <= S_CHK;
            S_CHK: begin
               if (hit) begin
                  row_q <= hit_row;
                  state <= S_RD_X;
               end else if (last_obj) begin
                  state <= S_DONE;
               end else begin
                  obj_q <= obj_q + OW'(1);
                  state <= S_RD_Y;
               end
            end
            S_RD_X: begin
               pic_q <= ram_o;
               state <= S_RD_A;
            end
            S_RD_A: begin
               x_q   <= ram_o;
               state <= S_LAT;
            end
            S_LAT: begin
               attr_q <= ram_o;
               if (ram_o[MO_ATTR_VFLIP]) row_q <= ROW_MAX - row_q;
               state  <= S_EMIT;
            end
            S_EMIT: begin
               if (obj_ready) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(MAX_PER_LINE - 1) && !last_obj) begin
                     ovf_q <= 1'b1;
                     state <= S_DONE;
                  end else if (last_obj) begin
                     state <= S_DONE;
                  end else begin
                     obj_q <= obj_q + OW'(1);
                     state <= S_RD_Y;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Reads are issued one state ahead of the state that consumes ram_o.
   always_comb begin
      ram_a   = '0;
      ram_r_n = 1'b1;
      case (state)
         S_RD_Y: begin
            ram_a   = 8'({obj_q, MO_Y});
            ram_r_n = 1'b0;
         end
         S_CHK: begin
            if (hit) begin
               ram_a   = 8'({obj_q, MO_PIC});
               ram_r_n = 1'b0;
            end
         end
         S_RD_X: begin
            ram_a   = 8'({obj_q, MO_X});
            ram_r_n = 1'b0;
         end
         S_RD_A: begin
            ram_a   = 8'({obj_q, MO_ATTR});
            ram_r_n = 1'b0;
         end
         default: ;
      endcase
   end

   assign obj_valid = (state == S_EMIT) && !line_start;
   assign obj_pic   = pic_q;
   assign obj_x     = x_q;
   assign obj_attr  = attr_q;
   assign obj_row   = row_q;
   assign scan_busy = (state != S_IDLE);
   assign scan_done = (state == S_DONE) && !line_start;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_mo_line_scanner.sv
// Scoreboard bench for mo_line_scanner: directed RAM images, expected descriptors queued at issue.
module tb_mo_line_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       line_start;
   logic [7:0] vline;
   logic [7:0] ram_a;
   logic       ram_r_n;
   logic [7:0] ram_o = 8'h00;
   logic       obj_valid;
   logic       obj_ready;
   logic [7:0] obj_pic;
   logic [7:0] obj_x;
   logic [7:0] obj_attr;
   logic [3:0] obj_row;
   logic       scan_busy;
   logic       scan_done;
   logic       overflow;

   mo_line_scanner #(.NUM_OBJ(64), .OBJ_H(16), .MAX_PER_LINE(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .vline      (vline),
      .ram_a      (ram_a),
      .ram_r_n    (ram_r_n),
      .ram_o      (ram_o),
      .obj_valid  (obj_valid),
      .obj_ready  (obj_ready),
      .obj_pic    (obj_pic),
      .obj_x      (obj_x),
      .obj_attr   (obj_attr),
      .obj_row    (obj_row),
      .scan_busy  (scan_busy),
      .scan_done  (scan_done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   always @(posedge clk) if (!ram_r_n) ram_o <= mem[ram_a];

   typedef struct packed {
      logic [7:0] pic;
      logic [7:0] x;
      logic [7:0] attr;
      logic [3:0] row;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] pic, input logic [7:0] x,
                               input logic [7:0] attr, input logic [3:0] row);
      exp_t r;
      r.pic = pic; r.x = x; r.attr = attr; r.row = row;
      return r;
   endfunction

   // Monitor: every accepted descriptor is compared against the head of the queue.
   always @(negedge clk) begin
      if (scan_done) n_done++;
      if (obj_valid && obj_ready) begin
         n_acc++;
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_emit: got pic %0h x %0h expected no descriptor", obj_pic, obj_x);
         end else begin
            e = q.pop_front();
            check("emit", {4'h0, obj_pic, obj_x, obj_attr, obj_row}, {4'h0, e.pic, e.x, e.attr, e.row});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ram();
      for (int i = 0; i < 256; i++) mem[i] = 8'h80;
   endtask

   task automatic set_obj(input int i, input logic [7:0] pic, input logic [7:0] y,
                          input logic [7:0] x, input logic [7:0] attr);
      mem[i*4+0] = pic;
      mem[i*4+1] = y;
      mem[i*4+2] = x;
      mem[i*4+3] = attr;
   endtask

   task automatic start_line(input logic [7:0] v);
      line_start = 1'b1;
      vline      = v;
      tick();
      line_start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic ovf);
      cyc = 0;
      ovf = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (scan_done) begin
            ovf = overflow;
            break;
         end
         if (cyc > 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no scan_done expected one within 3000 cycles");
            break;
         end
      end
      tick();
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!obj_valid && n < 500) begin
         tick();
         n++;
      end
      if (!obj_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL valid_timeout: got obj_valid 0 expected 1 within 500 cycles");
      end
   endtask

   initial begin
      int   cyc;
      logic ovf;
      int   acc0;
      int   done0;

      reset      = 1'b1;
      line_start = 1'b0;
      vline      = 8'h00;
      obj_ready  = 1'b1;
      clear_ram();
      repeat (3) tick();

      check("rst_valid", obj_valid, 0);
      check("rst_ram_r_n", ram_r_n, 1);
      check("rst_ram_a", ram_a, 0);
      check("rst_busy_done_ovf", {scan_busy, scan_done, overflow}, 0);
      check("rst_obj", {obj_pic, obj_x, obj_attr, obj_row}, 0);
      reset = 1'b0;
      tick();

      // Empty RAM: 64 misses at 2 cycles each, DONE in cycle 129.
      acc0 = n_acc;
      start_line(8'h10);
      check("busy_after_start", scan_busy, 1);
      wait_done(cyc, ovf);
      check("empty_done_cycle", cyc, 129);
      check("empty_ovf", ovf, 0);
      check("empty_no_emit", n_acc - acc0, 0);

      // Single hit, obj3 Y=0x0C on line 0x10 -> row 4.
      set_obj(3, 8'h21, 8'h0C, 8'h40, 8'h05);
      q.push_back(mk(8'h21, 8'h40, 8'h05, 4'd4));
      start_line(8'h10);
      wait_done(cyc, ovf);
      check("hit_q_empty", q.size(), 0);
      check("hit_ovf", ovf, 0);

      // Vertical flip: row 15-4 = 11.
      set_obj(3, 8'h21, 8'h0C, 8'h40, 8'h85);
      q.push_back(mk(8'h21, 8'h40, 8'h85, 4'd11));
      start_line(8'h10);
      wait_done(cyc, ovf);
      check("vflip_q_empty", q.size(), 0);

      // Y wrap: 0x03 - 0xFA = 9 mod 256.
      set_obj(3, 8'h21, 8'hFA, 8'h40, 8'h05);
      q.push_back(mk(8'h21, 8'h40, 8'h05, 4'd9));
      start_line(8'h03);
      wait_done(cyc, ovf);
      check("wrap_q_empty", q.size(), 0);

      // Ten hits: only objects 0..7 emitted, overflow at DONE.
      clear_ram();
      for (int i = 0; i < 10; i++) set_obj(i, 8'(i), 8'h10, 8'(8'h20 + i), 8'(i));
      for (int i = 0; i < 8; i++) q.push_back(mk(8'(i), 8'(8'h20 + i), 8'(i), 4'd0));
      acc0 = n_acc;
      start_line(8'h10);
      wait_done(cyc, ovf);
      check("ovf_flag", ovf, 1);
      check("ovf_emit_count", n_acc - acc0, 8);
      check("ovf_q_empty", q.size(), 0);

      // Stall in EMIT for 20 cycles.
      clear_ram();
      set_obj(3, 8'h21, 8'h0C, 8'h40, 8'h05);
      q.push_back(mk(8'h21, 8'h40, 8'h05, 4'd4));
      obj_ready = 1'b0;
      acc0 = n_acc;
      start_line(8'h10);
      wait_valid();
      for (int k = 0; k < 20; k++) begin
         check("stall_hold", {obj_valid, ram_r_n, obj_pic, obj_x, obj_attr, obj_row},
               {1'b1, 1'b1, 8'h21, 8'h40, 8'h05, 4'd4});
         tick();
      end
      obj_ready = 1'b1;
      wait_done(cyc, ovf);
      check("stall_single_accept", n_acc - acc0, 1);
      check("stall_q_empty", q.size(), 0);

      // Abort during EMIT of obj5, then full rescan of objects 0..5.
      clear_ram();
      for (int i = 0; i < 6; i++) set_obj(i, 8'(i), 8'h10, 8'(8'h30 + i), 8'(i));
      for (int i = 0; i < 5; i++) q.push_back(mk(8'(i), 8'(8'h30 + i), 8'(i), 4'd0));
      for (int i = 0; i < 6; i++) q.push_back(mk(8'(i), 8'(8'h30 + i), 8'(i), 4'd0));
      obj_ready = 1'b0;
      done0 = n_done;
      start_line(8'h10);
      for (int k = 0; k < 5; k++) begin
         wait_valid();
         obj_ready = 1'b1;
         tick();
         obj_ready = 1'b0;
      end
      wait_valid();
      check("abort_at_obj5", obj_pic, 8'h05);
      line_start = 1'b1;
      vline      = 8'h10;
      #1;
      check("abort_valid_same", obj_valid, 0);
      tick();
      line_start = 1'b0;
      check("abort_valid_next", obj_valid, 0);
      obj_ready = 1'b1;
      wait_done(cyc, ovf);
      check("abort_one_done", n_done - done0, 1);
      check("abort_q_empty", q.size(), 0);

      // Reset in the middle of a hit sequence.
      start_line(8'h10);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("midrst_outputs", {scan_busy, ram_r_n, obj_valid, scan_done, overflow}, 5'b01000);
      check("midrst_obj", {obj_pic, obj_x, obj_attr, obj_row}, 0);
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
